// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequencer between writeback and the shared TLB ports.
// Takes one TLB management instruction at a time (SRCH/RD/WR/FILL/INV)
// over valid/ready, fires a single-cycle strobe in EXEC and reports the
// result in RESP. FILL index comes from an 8-bit maximal-length LFSR.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   flush                 pipeline flush; blocks accept, cancels op
//   req_*                 request handshake and INVTLB operands
//   csr_vppn/asid/index   CSR state used by SRCH/RD/WR
//   s1_*                  TLB port-1 search inputs / hit result
//   tlb_we, tlb_w_index   TLB write strobe and index
//   tlb_r_index           TLB read index
//   invtlb_valid/op       invalidate strobe and op
//   tlbrd_we, tlbsrch_en  CSR capture strobes
//   resp_*                completion pulse with hit/index
module tlb_op_ctrl #(
  parameter int          TLBNUM    = 16,
  parameter int          IDX_W     = $clog2(TLBNUM),
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [4:0]       req_invop,
  input  logic [9:0]       req_asid,
  input  logic [31:0]      req_va,
  input  logic [18:0]      csr_vppn,
  input  logic [9:0]       csr_asid,
  input  logic [IDX_W-1:0] csr_index,
  output logic [18:0]      s1_vppn,
  output logic             s1_va_bit12,
  output logic [9:0]       s1_asid,
  input  logic             s1_found,
  input  logic [IDX_W-1:0] s1_index,
  output logic             tlb_we,
  output logic [IDX_W-1:0] tlb_w_index,
  output logic [IDX_W-1:0] tlb_r_index,
  output logic             invtlb_valid,
  output logic [4:0]       invtlb_op,
  output logic             tlbrd_we,
  output logic             tlbsrch_en,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [IDX_W-1:0] resp_index
);

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  // Only va[31:12] is ever driven onto port 1, so the low bits are dropped.
  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  invop;
    logic [9:0]  asid;
    logic [19:0] va_hi;
  } req_t;

  state_t           state;
  req_t             req_q;
  logic [7:0]       lfsr;
  logic             hit_q;
  logic [IDX_W-1:0] idx_q;

  logic unused_va;
  assign unused_va = ^req_va[11:0];

  logic exec_ok, resp_ok, inv_ok;
  // Flush and reset kill the current cycle's strobe/response combinationally.
  assign exec_ok   = (state == S_EXEC) & ~flush & ~reset;
  assign resp_ok   = (state == S_RESP) & ~flush & ~reset;
  assign inv_ok    = (req_q.op == OP_INV) & (req_q.invop <= 5'd6);
  assign req_ready = (state == S_IDLE) & ~flush;

  always_comb begin
    s1_vppn      = csr_vppn;
    s1_va_bit12  = 1'b0;
    s1_asid      = csr_asid;
    tlb_we       = 1'b0;
    tlbrd_we     = 1'b0;
    tlbsrch_en   = 1'b0;
    invtlb_valid = 1'b0;
    invtlb_op    = 5'd0;
    tlb_r_index  = csr_index;
    tlb_w_index  = (req_q.op == OP_FILL) ? lfsr[IDX_W-1:0] : csr_index;
    if (exec_ok) begin
      case (req_q.op)
        OP_SRCH: tlbsrch_en = 1'b1;
        OP_RD:   tlbrd_we   = 1'b1;
        OP_WR,
        OP_FILL: tlb_we     = 1'b1;
        OP_INV: if (inv_ok) begin
          invtlb_valid = 1'b1;
          invtlb_op    = req_q.invop;
          if (req_q.invop >= 5'd4) s1_asid = req_q.asid;
          if (req_q.invop >= 5'd5) begin
            s1_vppn     = req_q.va_hi[19:1];
            s1_va_bit12 = req_q.va_hi[0];
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = resp_ok;
  assign resp_hit   = resp_ok & hit_q;
  assign resp_index = resp_ok ? idx_q : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      req_q <= '0;
      lfsr  <= LFSR_SEED;
      hit_q <= 1'b0;
      idx_q <= '0;
    end else begin
      // Free-running, including through flush, so FILL indices stay spread.
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      case (state)
        S_IDLE: if (req_valid && req_ready) begin
          req_q.op    <= req_op;
          req_q.invop <= req_invop;
          req_q.asid  <= req_asid;
          req_q.va_hi <= req_va[31:12];
          state       <= S_EXEC;
        end
        S_EXEC: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            state <= S_RESP;
            hit_q <= (req_q.op == OP_SRCH) & s1_found;
            case (req_q.op)
              OP_SRCH:      idx_q <= s1_index;
              OP_RD, OP_WR: idx_q <= csr_index;
              OP_FILL:      idx_q <= lfsr[IDX_W-1:0];
              default:      idx_q <= '0;
            endcase
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/tlb_op_ctrl.md
Name: tlb_op_ctrl

Overview:
- Sequencer between the writeback stage and the shared TLB search/read/write/invalidate ports.
- Accepts one TLB management instruction at a time (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) over a valid/ready handshake.
- Drives the TLB port-1 and write/read/invalidate controls with single-cycle strobes, then returns results to the CSR logic.
- Replaces ad-hoc random fill-index generation with a synthesizable LFSR.

Parameters:
- TLBNUM, 16, number of TLB entries (power of two).
- IDX_W, 4, index width, equal to log2(TLBNUM).
- LFSR_SEED, 8'hA5, nonzero LFSR reset value.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  pipeline flush (exception/ertn from WB)
- req_valid  in  1  request valid
- req_ready  out  1  controller can accept a request
- req_op  in  3  0=SRCH, 1=RD, 2=WR, 3=FILL, 4=INV; 5-7 reserved
- req_invop  in  5  INVTLB op field
- req_asid  in  10  INVTLB rj[9:0]
- req_va  in  32  INVTLB rk value
- csr_vppn  in  19  TLBEHI.VPPN
- csr_asid  in  10  ASID.ASID
- csr_index  in  IDX_W  TLBIDX.Index
- s1_vppn  out  19  TLB port-1 VPPN
- s1_va_bit12  out  1  TLB port-1 VA bit 12
- s1_asid  out  10  TLB port-1 ASID
- s1_found  in  1  TLB port-1 hit
- s1_index  in  IDX_W  TLB port-1 hit index
- tlb_we  out  1  TLB write strobe
- tlb_w_index  out  IDX_W  TLB write index
- tlb_r_index  out  IDX_W  TLB read index
- invtlb_valid  out  1  invalidate strobe
- invtlb_op  out  5  invalidate op
- tlbrd_we  out  1  CSR capture strobe for TLB read data
- tlbsrch_en  out  1  CSR capture strobe for search result
- resp_valid  out  1  operation complete
- resp_hit  out  1  SRCH hit result
- resp_index  out  IDX_W  SRCH hit index, or index written/read

Behaviour:
- States: IDLE, EXEC, RESP. Reset: state=IDLE, latched request=0, lfsr=LFSR_SEED.
- Reset values of outputs: all strobes 0, resp_valid=0, resp_hit=0, resp_index=0, req_ready=1.
- req_ready = (state==IDLE) & ~flush.
- IDLE: when req_valid & req_ready, latch op, invop, asid, va, then go to EXEC. Otherwise stay in IDLE.
- EXEC (exactly one cycle), then go to RESP:
  - SRCH: s1_vppn=csr_vppn, s1_va_bit12=0, s1_asid=csr_asid. Assert tlbsrch_en; latch s1_found and s1_index.
  - RD: tlb_r_index=csr_index; assert tlbrd_we.
  - WR: assert tlb_we with tlb_w_index=csr_index.
  - FILL: assert tlb_we with tlb_w_index=lfsr[IDX_W-1:0], using the lfsr value in this cycle.
  - INV: if invop<=6, assert invtlb_valid with invtlb_op=invop.
    - For ops 4/5/6, s1_asid=asid[9:0].
    - For ops 5/6, s1_vppn=va[31:13] and s1_va_bit12=va[12].
    - If invop>6, no strobe is asserted (treated as a NOP).
  - Reserved op: no strobe asserted.
- RESP: resp_valid=1 for one cycle, then go to IDLE.
  - resp_hit is the latched hit for SRCH, otherwise 0.
  - resp_index is the latched s1_index for SRCH, the index used for RD/WR/FILL, otherwise 0.
- Outside EXEC, s1_* outputs carry the SRCH values (csr_vppn/csr_asid, bit12=0). All strobes are 0.
- Latency: accept in cycle N, strobe in N+1, resp_valid in N+2. Back-to-back throughput is one op per 3 cycles.
- flush:
  - In IDLE: blocks acceptance.
  - In EXEC: suppresses all strobes and forces IDLE (no resp).
  - In RESP: suppresses resp_valid and forces IDLE.
- LFSR:
  - 8-bit, advances every cycle including during flush: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Never reaches 0; period 255.
- Reset has priority over flush; reset mid-operation returns to IDLE with no strobe and no resp.
- Strobes are mutually exclusive, and at most one strobe pulse occurs per accepted request.

Test Plan:
- SRCH hit: csr_vppn=19'h00123, csr_asid=10'h5. TLB model returns found=1, index=7. Request accepted at N -> tlbsrch_en=1 at N+1; at N+2 resp_valid=1, resp_hit=1, resp_index=7.
- FILL index: request accepted in the first cycle after reset (lfsr=A5) -> EXEC lfsr=4A, tlb_we=1, tlb_w_index=4'hA; resp_index=4'hA.
- INVTLB op 5: asid=10'h3, va=32'h0040_3000 -> at EXEC invtlb_valid=1, invtlb_op=5, s1_asid=3, s1_vppn=19'h00201, s1_va_bit12=1. Also: invop=9 -> no strobe, resp_valid=1 with resp_hit=0.
- Flush in EXEC of a WR (csr_index=3) -> tlb_we stays 0, no resp_valid, req_ready=1 the next cycle.
- Back-to-back RD then WR with req_valid held high -> second accept at N+3, tlbrd_we at N+1, tlb_we at N+4, two resp pulses at N+2 and N+5.
- Reset asserted during RESP -> resp_valid=0 in that cycle, state IDLE, lfsr=A5 on the next cycle.
